// File: rtl/sp_ram_ctrl.sv
// Single-port RAM front end: clears every word after reset, then shares the one
// RAM port between a write channel and a read channel with alternating priority.
module sp_ram_ctrl #(
   parameter int unsigned      WIDTH      = 8,
   parameter int unsigned      DEPTH      = 8,
   parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b0}}
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_valid,
   output logic                     rd_ready,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic                     rsp_valid,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     init_done,
   output logic                     ram_ena,
   output logic                     ram_wea,
   output logic [$clog2(DEPTH)-1:0] ram_addr,
   output logic [WIDTH-1:0]         ram_din,
   input  logic [WIDTH-1:0]         ram_dout
);

   localparam int unsigned     AW         = $clog2(DEPTH);
   localparam logic [AW-1:0]   LAST_ADDR  = AW'(DEPTH - 1);
   localparam int unsigned     RSP_STAGES = 2;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [AW-1:0]    cnt_reg, cnt_next;
   logic             prio_wr_reg, prio_wr_next;
   logic             init_done_reg, init_done_next;
   logic             ram_ena_reg, ram_ena_next;
   logic             ram_wea_reg, ram_wea_next;
   logic [AW-1:0]    ram_addr_reg, ram_addr_next;
   logic [WIDTH-1:0] ram_din_reg, ram_din_next;
   logic             wr_accept, rd_accept;

   logic [RSP_STAGES-1:0] rsp_pipe_reg;
   logic [RSP_STAGES-1:0] rsp_pipe_next;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      prio_wr_next   = prio_wr_reg;
      init_done_next = init_done_reg;
      ram_ena_next   = 1'b0;
      ram_wea_next   = 1'b0;
      ram_addr_next  = ram_addr_reg;
      ram_din_next   = ram_din_reg;
      wr_ready       = 1'b0;
      rd_ready       = 1'b0;
      wr_accept      = 1'b0;
      rd_accept      = 1'b0;

      case (state_reg)
         ST_INIT: begin
            ram_ena_next  = 1'b1;
            ram_wea_next  = 1'b1;
            ram_addr_next = cnt_reg;
            ram_din_next  = INIT_VALUE;
            if (cnt_reg == LAST_ADDR) begin
               cnt_next       = '0;
               state_next     = ST_RUN;
               init_done_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         ST_RUN: begin
            // Under contention exactly one side is ready: the priority holder.
            wr_ready  = !rd_valid || prio_wr_reg;
            rd_ready  = !wr_valid || !prio_wr_reg;
            wr_accept = wr_valid && wr_ready;
            rd_accept = rd_valid && rd_ready;
            if (wr_valid && rd_valid) begin
               prio_wr_next = !prio_wr_reg;
            end
            if (wr_accept) begin
               ram_ena_next  = 1'b1;
               ram_wea_next  = 1'b1;
               ram_addr_next = wr_addr;
               ram_din_next  = wr_data;
            end else if (rd_accept) begin
               ram_ena_next  = 1'b1;
               ram_addr_next = rd_addr;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_INIT;
         cnt_reg       <= '0;
         prio_wr_reg   <= 1'b1;
         init_done_reg <= 1'b0;
         ram_ena_reg   <= 1'b0;
         ram_wea_reg   <= 1'b0;
         ram_addr_reg  <= '0;
         ram_din_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         prio_wr_reg   <= prio_wr_next;
         init_done_reg <= init_done_next;
         ram_ena_reg   <= ram_ena_next;
         ram_wea_reg   <= ram_wea_next;
         ram_addr_reg  <= ram_addr_next;
         ram_din_reg   <= ram_din_next;
      end
   end

   // Stage 0 notes a read sitting on the RAM port; the last stage lines up with ram_dout.
   genvar gi;
   generate
      for (gi = 0; gi < RSP_STAGES; gi++) begin : g_rsp_pipe
         if (gi == 0) begin : g_head
            assign rsp_pipe_next[gi] = ram_ena_reg && !ram_wea_reg;
         end else begin : g_tail
            assign rsp_pipe_next[gi] = rsp_pipe_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_pipe_reg <= '0;
      end else begin
         rsp_pipe_reg <= rsp_pipe_next;
      end
   end

   assign rsp_valid = rsp_pipe_reg[RSP_STAGES-1];
   assign rsp_data  = ram_dout;
   assign init_done = init_done_reg;
   assign ram_ena   = ram_ena_reg;
   assign ram_wea   = ram_wea_reg;
   assign ram_addr  = ram_addr_reg;
   assign ram_din   = ram_din_reg;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl: RAM model with two-cycle read path, a cycle-level
// scoreboard of the controller's rules, and directed scenarios with literal pins.
module tb_sp_ram_ctrl;

   localparam int         WIDTH      = 8;
   localparam int         DEPTH      = 8;
   localparam int         AW         = 3;
   localparam logic [7:0] INIT_VALUE = 8'hA5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [AW-1:0] wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          rd_valid = 1'b0;
   logic          rd_ready;
   logic [AW-1:0] rd_addr = '0;
   logic          rsp_valid;
   logic [7:0]    rsp_data;
   logic          init_done;
   logic          ram_ena;
   logic          ram_wea;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic [7:0]    ram_dout;

   always #5 clk = ~clk;

   sp_ram_ctrl #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .INIT_VALUE(INIT_VALUE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_valid(rd_valid),
      .rd_ready(rd_ready),
      .rd_addr(rd_addr),
      .rsp_valid(rsp_valid),
      .rsp_data(rsp_data),
      .init_done(init_done),
      .ram_ena(ram_ena),
      .ram_wea(ram_wea),
      .ram_addr(ram_addr),
      .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   // RAM environment: array read on the edge after the port is driven, then an output register.
   logic [7:0] ram_mem [DEPTH];
   logic [7:0] ram_q;
   always @(posedge clk) begin
      if (ram_ena) begin
         if (ram_wea) ram_mem[ram_addr] <= ram_din;
         ram_q <= ram_mem[ram_addr];
      end
      ram_dout <= ram_q;
   end

   // Edges since reset release.
   int cyc = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   typedef struct {
      int         due;
      logic [7:0] data;
   } rsp_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   bit         m_prio;
   int         acc_kind;
   logic [AW-1:0] acc_addr;
   logic [7:0] m_din;
   logic [7:0] m_mem [DEPTH];
   rsp_t       exp_q[$];
   logic [7:0] obs_rsp[$];
   int         obs_cyc[$];
   int         init_rise = -1;
   logic [5:0] glog = '0;
   int         last_acc_edge = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: everything observed after edge k and before edge k+1.
   always @(negedge clk) begin
      bit run, exp_wr, exp_rd, exp_v;
      if (rst) begin
         check("rst_ram_ena", 32'(ram_ena), 32'(0));
         check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
         check("rst_wr_ready", 32'(wr_ready), 32'(0));
         check("rst_rd_ready", 32'(rd_ready), 32'(0));
         check("rst_init_done", 32'(init_done), 32'(0));
         exp_q.delete();
         m_prio    = 1'b1;
         acc_kind  = 0;
         m_din     = '0;
         init_rise = -1;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT_VALUE;
      end else begin
         run = (cyc >= DEPTH);
         if (cyc == 0) begin
            check("idle_ena", 32'(ram_ena), 32'(0));
            check("idle_addr", 32'(ram_addr), 32'(0));
            check("idle_din", 32'(ram_din), 32'(0));
         end else if (cyc <= DEPTH) begin
            check("init_ena", 32'(ram_ena), 32'(1));
            check("init_wea", 32'(ram_wea), 32'(1));
            check("init_addr", 32'(ram_addr), 32'(cyc - 1));
            check("init_din", 32'(ram_din), 32'(INIT_VALUE));
            m_din = INIT_VALUE;
         end else begin
            check("port_ena", 32'(ram_ena), 32'(acc_kind != 0));
            check("port_wea", 32'(ram_wea), 32'(acc_kind == 1));
            if (acc_kind != 0) begin
               check("port_addr", 32'(ram_addr), 32'(acc_addr));
               check("port_din", 32'(ram_din), 32'(m_din));
            end
         end
         check("init_done", 32'(init_done), 32'(run));
         if (init_done === 1'b1 && init_rise < 0) init_rise = cyc;

         while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
         exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
         if (exp_v) begin
            check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
         end
         if (rsp_valid === 1'b1) begin
            obs_rsp.push_back(rsp_data);
            obs_cyc.push_back(cyc);
            $display("rsp   cyc=%0d data=%02h", cyc, rsp_data);
         end

         // Fairness: a lone requester is always served; a contended cycle goes to the holder.
         exp_wr = run && (!rd_valid || m_prio);
         exp_rd = run && (!wr_valid || !m_prio);
         check("wr_ready", 32'(wr_ready), 32'(exp_wr));
         check("rd_ready", 32'(rd_ready), 32'(exp_rd));
         if (run && wr_valid && rd_valid) glog = {glog[4:0], wr_ready};

         acc_kind = 0;
         if (wr_valid && exp_wr) begin
            acc_kind = 1;
            acc_addr = wr_addr;
            m_din    = wr_data;
            m_mem[wr_addr] = wr_data;
            $display("write edge=%0d addr=%0d data=%02h", cyc + 1, wr_addr, wr_data);
         end else if (rd_valid && exp_rd) begin
            acc_kind = 2;
            acc_addr = rd_addr;
            exp_q.push_back('{cyc + 3, m_mem[rd_addr]});
            $display("read  edge=%0d addr=%0d", cyc + 1, rd_addr);
         end
         if (run && wr_valid && rd_valid) m_prio = !m_prio;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input bit is_wr);
      bit ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (is_wr ? (wr_ready === 1'b1) : (rd_ready === 1'b1)) begin
            last_acc_edge = cyc + 1;
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         tick();
      end else begin
         n_cmp++;
         n_bad++;
         $display("FAIL handshake_timeout: got no ready, expected ready within 40 cycles (t=%0t)", $time);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
      wr_addr  = a;
      wr_data  = d;
      wr_valid = 1'b1;
      wait_hs(1'b1);
      wr_valid = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      rd_addr  = a;
      rd_valid = 1'b1;
      wait_hs(1'b0);
      rd_valid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before 400000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      logic [5:0] exp_glog;
      logic [7:0] exp_byte;

      #2 rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Request raised during the sweep is held off until edge DEPTH+1.
      tick();
      wr_addr  = 3'd6;
      wr_data  = 8'h77;
      wr_valid = 1'b1;
      #1 check("init_wr_ready_low", 32'(wr_ready), 32'(0));
      wait_hs(1'b1);
      wr_valid = 1'b0;
      check("init_acc_edge", 32'(last_acc_edge), 32'(9));
      check("init_rise_edge", 32'(init_rise), 32'(8));

      for (int i = 0; i < DEPTH; i++) do_read(AW'(i));
      repeat (4) tick();
      check("readall_count", 32'(obs_rsp.size()), 32'(8));
      check("readall_d0", 32'(obs_rsp[0]), 32'(8'hA5));
      check("readall_d6", 32'(obs_rsp[6]), 32'(8'h77));
      check("readall_d7", 32'(obs_rsp[7]), 32'(8'hA5));
      check("readall_first_cyc", 32'(obs_cyc[0]), 32'(12));

      // Write then read the same address on the next cycle.
      n0 = obs_rsp.size();
      do_write(3'd5, 8'h3C);
      do_read(3'd5);
      repeat (4) tick();
      check("wr_rd_count", 32'(obs_rsp.size()), 32'(n0 + 1));
      check("wr_rd_data", 32'(obs_rsp[n0]), 32'(8'h3C));
      check("wr_rd_latency", 32'(obs_cyc[n0]), 32'(last_acc_edge + 2));

      // Six contended cycles alternate W,R,W,R,W,R.
      glog     = '0;
      wr_addr  = 3'd1;
      wr_data  = 8'h55;
      rd_addr  = 3'd2;
      wr_valid = 1'b1;
      rd_valid = 1'b1;
      repeat (6) tick();
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      exp_glog = 6'b101010;
      check("grant_order", 32'(glog), 32'(exp_glog));
      repeat (4) tick();

      // Back-to-back reads return back-to-back responses in order.
      for (int i = 0; i < 4; i++) do_write(AW'(i), 8'(8'h10 + i));
      n0 = obs_rsp.size();
      for (int i = 0; i < 4; i++) do_read(AW'(i));
      repeat (5) tick();
      check("b2b_count", 32'(obs_rsp.size()), 32'(n0 + 4));
      for (int i = 0; i < 4; i++) begin
         exp_byte = 8'h10;
         exp_byte = exp_byte + 8'(i);
         check("b2b_data", 32'(obs_rsp[n0 + i]), 32'(exp_byte));
      end
      check("b2b_span", 32'(obs_cyc[n0 + 3] - obs_cyc[n0]), 32'(3));

      // Reset in the middle of the sweep, at address 3.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      check("sweep_addr3", 32'(ram_addr), 32'(3));
      rst = 1'b1;
      #1 check("sweep_rst_ena_drop", 32'(ram_ena), 32'(0));
      tick();
      rst = 1'b0;
      repeat (DEPTH + 1) tick();
      check("sweep_restart_rise", 32'(init_rise), 32'(DEPTH));

      // Reset one cycle after a read is accepted: nothing comes back.
      rd_addr  = 3'd4;
      rd_valid = 1'b1;
      tick();
      tick();
      check("pre_rst_ena", 32'(ram_ena), 32'(1));
      n0 = obs_rsp.size();
      rst      = 1'b1;
      rd_valid = 1'b0;
      #1 check("rd_rst_ena_drop", 32'(ram_ena), 32'(0));
      tick();
      rst = 1'b0;
      repeat (DEPTH + 4) tick();
      check("rd_rst_no_rsp", 32'(obs_rsp.size()), 32'(n0));

      do_write(3'd7, 8'h9A);
      do_read(3'd7);
      repeat (4) tick();
      check("final_data", 32'(obs_rsp[$]), 32'(8'h9A));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
